// File: rtl/alu_op_sequencer_if.sv
// Command/response, register-load and ALU drive bundle for alu_op_sequencer.
// slave = the sequencer, master = command source plus the combinational ALU.
interface alu_op_sequencer_if;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [1:0]        cmd_rd;
    logic [1:0]        cmd_ra;
    logic [1:0]        cmd_rb;
    logic              cmd_imm_en;
    logic signed [3:0] cmd_imm;

    logic              ld_en;
    logic [1:0]        ld_idx;
    logic signed [3:0] ld_data;

    logic signed [3:0] alu_a;
    logic signed [3:0] alu_b;
    logic [1:0]        alu_select;
    logic signed [3:0] alu_out;
    logic              alu_carry;
    logic              alu_sign;
    logic              alu_overflow;
    logic              alu_parity;
    logic              alu_zero;

    logic              rsp_valid;
    logic              rsp_ready;
    logic signed [3:0] rsp_data;
    logic [4:0]        rsp_flags;

    logic              sticky_ovf;
    logic              sticky_div0;
    logic              clr_sticky;

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm_en, cmd_imm,
        input  ld_en, ld_idx, ld_data,
        input  alu_out, alu_carry, alu_sign, alu_overflow, alu_parity, alu_zero,
        input  rsp_ready, clr_sticky,
        output cmd_ready, alu_a, alu_b, alu_select,
        output rsp_valid, rsp_data, rsp_flags, sticky_ovf, sticky_div0
    );

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm_en, cmd_imm,
        output ld_en, ld_idx, ld_data,
        output alu_out, alu_carry, alu_sign, alu_overflow, alu_parity, alu_zero,
        output rsp_ready, clr_sticky,
        input  cmd_ready, alu_a, alu_b, alu_select,
        input  rsp_valid, rsp_data, rsp_flags, sticky_ovf, sticky_div0
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Command-driven initiator for the 4-bit signed ALU: operand fetch, settle, capture, writeback.
// Optional sticky overflow/div-by-zero status is built only when ALU_SEQ_STICKY_EN is defined.
module alu_op_sequencer #(
    parameter int ISSUE_WAIT = 1
) (
    input logic               clk,
    input logic               rst_n,
    alu_op_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t            state, state_nxt;
    logic [1:0]        cnt;
    logic [1:0]        rd_q;
    logic signed [3:0] a_q, b_q, data_q;
    logic [1:0]        sel_q;
    logic [4:0]        flags_q;
    logic signed [3:0] regs [4];
    logic              accept, capture, div0;

    assign accept  = bus.cmd_valid && (state == IDLE);
    assign capture = (state == ISSUE) && (cnt == 2'd0);
    // b_q is the operand actually presented to the ALU, so it decides div-by-zero
    assign div0    = (sel_q == 2'd3) && (b_q == 4'sd0);

    assign bus.cmd_ready  = (state == IDLE);
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_data   = data_q;
    assign bus.rsp_flags  = flags_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_select = sel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.cmd_valid)   state_nxt = ISSUE;
            ISSUE:   if (cnt == 2'd0)     state_nxt = RESP;
            RESP:    if (bus.rsp_ready)   state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 2'd0;
            rd_q    <= 2'd0;
            a_q     <= 4'sd0;
            b_q     <= 4'sd0;
            sel_q   <= 2'd0;
            data_q  <= 4'sd0;
            flags_q <= 5'd0;
            for (int i = 0; i < 4; i++) regs[i] <= 4'sd0;
        end else begin
            // operands are sampled before any same-edge load or later writeback lands
            if (accept) begin
                a_q   <= regs[bus.cmd_ra];
                b_q   <= bus.cmd_imm_en ? bus.cmd_imm : regs[bus.cmd_rb];
                sel_q <= bus.cmd_op;
                rd_q  <= bus.cmd_rd;
                cnt   <= 2'(ISSUE_WAIT - 1);
            end else if (state == ISSUE && cnt != 2'd0) begin
                cnt <= cnt - 2'd1;
            end
            if (state == IDLE && bus.ld_en) regs[bus.ld_idx] <= bus.ld_data;
            if (capture) begin
                data_q  <= bus.alu_out;
                flags_q <= {bus.alu_carry, bus.alu_sign, bus.alu_overflow,
                            bus.alu_parity, bus.alu_zero};
                if (!div0) regs[rd_q] <= bus.alu_out;
            end
        end
    end

`ifdef ALU_SEQ_STICKY_EN
    logic sticky_ovf_q, sticky_div0_q;

    // a set on a capture edge takes priority over a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf_q  <= 1'b0;
            sticky_div0_q <= 1'b0;
        end else begin
            if (capture && bus.alu_overflow && sel_q != 2'd3) sticky_ovf_q <= 1'b1;
            else if (bus.clr_sticky)                          sticky_ovf_q <= 1'b0;
            if (capture && div0)                              sticky_div0_q <= 1'b1;
            else if (bus.clr_sticky)                          sticky_div0_q <= 1'b0;
        end
    end

    assign bus.sticky_ovf  = sticky_ovf_q;
    assign bus.sticky_div0 = sticky_div0_q;
`else
    logic unused_clr;
    assign unused_clr      = bus.clr_sticky;
    assign bus.sticky_ovf  = 1'b0;
    assign bus.sticky_div0 = 1'b0;
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU on the bus, register-file model, directed table,
// hand sequences for overflow/div0/backpressure/reset, then random commands.
module tb_alu_op_sequencer;
    localparam int W = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errs = 0;
    int   checks = 0;

    logic signed [3:0] mreg [4];
    logic              m_so = 1'b0;
    logic              m_sd = 1'b0;

    alu_op_sequencer_if bus ();

    alu_op_sequencer #(.ISSUE_WAIT(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // returns {result[3:0], carry, sign, overflow, parity(even), zero}
    function automatic logic [8:0] alu_f(input logic [1:0] op, input logic signed [3:0] a,
                                         input logic signed [3:0] b);
        int s, ua, ub;
        logic c, v;
        logic [3:0] r;
        ua = {28'd0, a};
        ub = {28'd0, b};
        c  = 1'b0;
        s  = 0;
        case (op)
            2'd0: begin s = int'(a) + int'(b); c = (ua + ub) > 15; end
            2'd1: begin s = int'(a) - int'(b); c = ua < ub; end
            2'd2: s = int'(a) * int'(b);
            default: s = (b == 4'sd0) ? 0 : int'(a) / int'(b);
        endcase
        v = (op == 2'd3 && b == 4'sd0) ? 1'b1 : (s > 7 || s < -8);
        r = s[3:0];
        return {r, c, r[3], v, ~^r, r == 4'd0};
    endfunction

    assign {bus.alu_out, bus.alu_carry, bus.alu_sign, bus.alu_overflow,
            bus.alu_parity, bus.alu_zero} = alu_f(bus.alu_select, bus.alu_a, bus.alu_b);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic ld(input logic [1:0] i, input logic signed [3:0] v);
        bus.ld_en = 1'b1; bus.ld_idx = i; bus.ld_data = v;
        @(posedge clk); #1;
        bus.ld_en = 1'b0;
        mreg[i] = v;
    endtask

    task automatic clr();
        bus.clr_sticky = 1'b1;
        @(posedge clk); #1;
        bus.clr_sticky = 1'b0;
        m_so = 1'b0; m_sd = 1'b0;
        chk("sticky_ovf_clr", bus.sticky_ovf, 0);
        chk("sticky_div0_clr", bus.sticky_div0, 0);
    endtask

    // A load already on ld_en when called is committed on the accept edge.
    task automatic do_cmd(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] ra,
                          input logic [1:0] rb, input logic ie, input logic signed [3:0] imm,
                          input int bp, input logic ld_resp,
                          output logic signed [3:0] d, output logic [4:0] f);
        logic signed [3:0] a, b, ed;
        logic [4:0] ef;
        logic [8:0] res;
        int n;
        a = mreg[ra];
        b = ie ? imm : mreg[rb];
        res = alu_f(op, a, b);
        ed = res[8:5];
        ef = res[4:0];
        chk("cmd_ready_idle", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_rd = rd; bus.cmd_ra = ra;
        bus.cmd_rb = rb; bus.cmd_imm_en = ie; bus.cmd_imm = imm;
        bus.rsp_ready = (bp == 0);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        if (bus.ld_en) begin
            mreg[bus.ld_idx] = bus.ld_data;
            bus.ld_en = 1'b0;
        end
        chk("alu_a", bus.alu_a, a);
        chk("alu_b", bus.alu_b, b);
        chk("alu_select", bus.alu_select, op);
        n = 0;
        while (!bus.rsp_valid && n < 16) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, W);
        d = bus.rsp_data;
        f = bus.rsp_flags;
        chk("rsp_data", d, ed);
        chk("rsp_flags", f, ef);
        if (!(op == 2'd3 && b == 4'sd0)) mreg[rd] = ed;
`ifdef ALU_SEQ_STICKY_EN
        if (ef[2] && op != 2'd3) m_so = 1'b1;
        if (op == 2'd3 && b == 4'sd0) m_sd = 1'b1;
`endif
        chk("sticky_ovf", bus.sticky_ovf, m_so);
        chk("sticky_div0", bus.sticky_div0, m_sd);
        if (bp > 0) begin
            // a stray command and a load while stalled must both be ignored
            bus.cmd_valid = 1'b1; bus.cmd_ra = ~ra;
            if (ld_resp) begin
                bus.ld_en = 1'b1; bus.ld_idx = 2'd0; bus.ld_data = mreg[0] + 4'sd1;
            end
            for (int i = 0; i < bp; i++) begin
                @(posedge clk); #1;
                chk("bp_valid", bus.rsp_valid, 1);
                chk("bp_data", bus.rsp_data, ed);
                chk("bp_flags", bus.rsp_flags, ef);
                chk("bp_cmd_ready", bus.cmd_ready, 0);
            end
            bus.cmd_valid = 1'b0; bus.ld_en = 1'b0; bus.rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("ready_after_rsp", bus.cmd_ready, 1);
        chk("valid_after_rsp", bus.rsp_valid, 0);
    endtask

    typedef struct {
        logic [1:0]        op, rd, ra, rb;
        logic              ie;
        logic signed [3:0] imm;
        logic signed [3:0] ed;
        logic [4:0]        ef;
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic signed [3:0] d;
        logic [4:0] f;
        tbl[0] = '{2'd0, 2'd2, 2'd0, 2'd1, 1'b0, 4'sd0,  4'sd5,  5'b00010};
        tbl[1] = '{2'd1, 2'd3, 2'd0, 2'd0, 1'b1, 4'sd5,  -4'sd2, 5'b11000};
        tbl[2] = '{2'd0, 2'd1, 2'd2, 2'd0, 1'b0, 4'sd0,  -4'sd8, 5'b01100};
        tbl[3] = '{2'd2, 2'd0, 2'd3, 2'd0, 1'b1, 4'sd3,  -4'sd6, 5'b01010};
        tbl[4] = '{2'd3, 2'd2, 2'd0, 2'd0, 1'b1, 4'sd2,  -4'sd3, 5'b01000};
        tbl[5] = '{2'd1, 2'd3, 2'd3, 2'd3, 1'b0, 4'sd0,  4'sd0,  5'b00011};
        for (int i = 0; i < 4; i++) mreg[i] = 4'sd0;
        bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_rd = 0; bus.cmd_ra = 0; bus.cmd_rb = 0;
        bus.cmd_imm_en = 0; bus.cmd_imm = 0; bus.ld_en = 0; bus.ld_idx = 0; bus.ld_data = 0;
        bus.rsp_ready = 0; bus.clr_sticky = 0;

        #3;
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_flags", bus.rsp_flags, 0);
        chk("rst_alu_a", bus.alu_a, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        ld(2'd0, 4'sd3);
        ld(2'd1, 4'sd2);
        for (int i = 0; i < 6; i++) begin
            do_cmd(tbl[i].op, tbl[i].rd, tbl[i].ra, tbl[i].rb, tbl[i].ie, tbl[i].imm, 0, 1'b0, d, f);
            chk($sformatf("tbl%0d_data", i), d, tbl[i].ed);
            chk($sformatf("tbl%0d_flags", i), f, tbl[i].ef);
        end
        clr();

        // overflow and sticky clear
        ld(2'd0, 4'sd7);
        do_cmd(2'd0, 2'd1, 2'd0, 2'd0, 1'b1, 4'sd1, 0, 1'b0, d, f);
        chk("ovf_data", d, -8);
        chk("ovf_flag", f[2], 1);
        chk("ovf_sign", f[3], 1);
        clr();

        // divide by zero leaves rd untouched
        ld(2'd3, 4'sd6);
        do_cmd(2'd3, 2'd3, 2'd3, 2'd0, 1'b1, 4'sd0, 0, 1'b0, d, f);
        chk("div0_data", d, 0);
        chk("div0_flags", f, 5'b00111);
        do_cmd(2'd0, 2'd0, 2'd3, 2'd0, 1'b1, 4'sd0, 0, 1'b0, d, f);
        chk("div0_r3_kept", d, 6);
        clr();

        // backpressure with ignored load to r0 (r0 is 6 here)
        do_cmd(2'd1, 2'd2, 2'd3, 2'd1, 1'b0, 4'sd0, 4, 1'b1, d, f);
        do_cmd(2'd0, 2'd1, 2'd0, 2'd0, 1'b1, 4'sd0, 0, 1'b0, d, f);
        chk("resp_ld_ignored", d, 6);

        // same-edge load and accept: operand sees old r1 (6), load lands
        bus.ld_en = 1'b1; bus.ld_idx = 2'd1; bus.ld_data = -4'sd3;
        do_cmd(2'd0, 2'd2, 2'd1, 2'd0, 1'b1, 4'sd1, 0, 1'b0, d, f);
        chk("ld_accept_old", d, 7);
        do_cmd(2'd0, 2'd0, 2'd1, 2'd0, 1'b1, 4'sd0, 0, 1'b0, d, f);
        chk("ld_accept_new", d, -3);

        // asynchronous reset while holding a response
        ld(2'd1, 4'sd3);
        bus.cmd_valid = 1; bus.cmd_op = 0; bus.cmd_rd = 2; bus.cmd_ra = 1;
        bus.cmd_imm_en = 1; bus.cmd_imm = 4'sd1; bus.rsp_ready = 0;
        @(posedge clk); #1;
        bus.cmd_valid = 0;
        repeat (W) @(posedge clk);
        #1;
        chk("pre_rst_valid", bus.rsp_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rsp_valid", bus.rsp_valid, 0);
        chk("arst_cmd_ready", bus.cmd_ready, 1);
        chk("arst_alu_a", bus.alu_a, 0);
        chk("arst_alu_b", bus.alu_b, 0);
        chk("arst_rsp_data", bus.rsp_data, 0);
        chk("arst_rsp_flags", bus.rsp_flags, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) mreg[i] = 4'sd0;
        m_so = 1'b0; m_sd = 1'b0;
        do_cmd(2'd0, 2'd0, 2'd1, 2'd2, 1'b0, 4'sd0, 0, 1'b0, d, f);
        chk("arst_regs_zero", d, 0);

        // random commands against the model
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) == 0) ld(2'($urandom_range(0, 3)), 4'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                bus.ld_en = 1'b1; bus.ld_idx = 2'($urandom_range(0, 3)); bus.ld_data = 4'($urandom);
            end
            do_cmd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0) ? 4'sd0 : 4'($urandom),
                   $urandom_range(0, 2), 1'($urandom_range(0, 1)), d, f);
            if ($urandom_range(0, 7) == 0) clr();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
